cla_addsub_pipe: RTL and testbench

Two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshakes on both sides.
- Stage 1 forms per-bit propagate/generate and 4-bit group PG/GG.
- Stage 2 resolves group carries through a second-level lookahead, then forms sum and flags.
- Sits between operand sourcing logic and the result consumer in the datapath; it is the clocked user of the 4-bit lookahead carry logic.

---
 rtl/cla_addsub_pipe.sv | 202 ++++++++++++++++++++
 tb/tb_cla_addsub_pipe.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_addsub_pipe.sv
// cla_addsub_pipe: two-stage pipelined carry-lookahead adder/subtractor.
//
// Stage 1 conditions the operands (B inverted and carry-in forced to 1 for
// subtraction) and registers per-bit propagate/generate plus 4-bit group
// propagate/generate. Stage 2 resolves the group carries with a second-level
// lookahead, forms the in-group carries, sum and flags, and registers them
// into the output registers.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand beat valid
//   in_ready   block can accept an operand beat (combinational from out_ready)
//   a, b       operands (WIDTH bits)
//   sub        1 = A - B, 0 = A + B + cin
//   cin        carry-in for addition, ignored when sub = 1
//   out_valid  result beat valid
//   out_ready  consumer accepts result beat
//   sum        result (WIDTH bits)
//   cout       carry-out (for subtraction, 1 = no borrow)
//   ovf        two's-complement signed overflow
//   zero       sum == 0
module cla_addsub_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NG = WIDTH / 4;

    // Group generate of a 4-bit slice: g3 | p3g2 | p3p2g1 | p3p2p1g0
    function automatic logic group_gen(input logic [3:0] p, input logic [3:0] g);
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    endfunction

    // Carry into each bit of a 4-bit slice given the slice carry-in
    function automatic logic [3:0] group_carries(input logic [3:0] p, input logic [3:0] g,
                                                 input logic ci);
        logic [3:0] c;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        return c;
    endfunction

    // Handshake / flow-control signals
    logic s1_valid_r;
    logic s2_valid_r;
    logic s1_load_s;
    logic s2_load_s;

    // Stage 1 combinational inputs and registers
    logic [WIDTH-1:0] b_eff_s;
    logic             c0_s;
    logic [WIDTH-1:0] p_in_s;
    logic [WIDTH-1:0] g_in_s;
    logic [NG-1:0]    pg_in_s;
    logic [NG-1:0]    gg_in_s;
    logic [WIDTH-1:0] p_r;
    logic [WIDTH-1:0] g_r;
    logic [NG-1:0]    pg_r;
    logic [NG-1:0]    gg_r;
    logic             c0_r;

    // Stage 2 combinational results and output registers
    logic [NG:0]      grp_c_s;
    logic [WIDTH-1:0] bit_c_s;
    logic [WIDTH-1:0] sum_s;
    logic             cout_s;
    logic             ovf_s;
    logic             zero_s;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;
    logic             zero_r;

    // Stage 2 advances when empty or its beat is being taken; stage 1 when
    // empty or stage 2 is advancing, which makes in_ready combinational.
    assign s2_load_s = ~s2_valid_r | out_ready;
    assign s1_load_s = ~s1_valid_r | s2_load_s;
    assign in_ready  = s1_load_s;

    // Operand conditioning and per-bit / per-group propagate-generate
    always_comb begin
        b_eff_s = b;
        c0_s    = cin;
        pg_in_s = '0;
        gg_in_s = '0;
        if (sub) begin
            b_eff_s = ~b;
            c0_s    = 1'b1;
        end else begin
            b_eff_s = b;
            c0_s    = cin;
        end
        p_in_s = a ^ b_eff_s;
        g_in_s = a & b_eff_s;
        for (int k = 0; k < NG; k++) begin
            pg_in_s[k] = &p_in_s[4*k +: 4];
            gg_in_s[k] = group_gen(p_in_s[4*k +: 4], g_in_s[4*k +: 4]);
        end
    end

    // Stage 1 register: payload captured only on an input transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            p_r        <= '0;
            g_r        <= '0;
            pg_r       <= '0;
            gg_r       <= '0;
            c0_r       <= 1'b0;
        end else if (s1_load_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                p_r  <= p_in_s;
                g_r  <= g_in_s;
                pg_r <= pg_in_s;
                gg_r <= gg_in_s;
                c0_r <= c0_s;
            end
        end
    end

    // Second-level lookahead: each group carry is the OR of expanded product
    // terms (GG[j] & PG[j+1..k]) and (c0 & PG[0..k]) rather than a ripple chain.
    always_comb begin
        logic prod_v;
        logic carry_v;
        prod_v     = 1'b0;
        carry_v    = 1'b0;
        grp_c_s    = '0;
        grp_c_s[0] = c0_r;
        for (int k = 0; k < NG; k++) begin
            carry_v = 1'b0;
            for (int j = 0; j <= k; j++) begin
                prod_v = gg_r[j];
                for (int m = j + 1; m <= k; m++) begin
                    prod_v = prod_v & pg_r[m];
                end
                carry_v = carry_v | prod_v;
            end
            prod_v = c0_r;
            for (int m = 0; m <= k; m++) begin
                prod_v = prod_v & pg_r[m];
            end
            grp_c_s[k+1] = carry_v | prod_v;
        end
    end

    // In-group carries, sum and flags
    always_comb begin
        bit_c_s = '0;
        for (int k = 0; k < NG; k++) begin
            bit_c_s[4*k +: 4] = group_carries(p_r[4*k +: 4], g_r[4*k +: 4], grp_c_s[k]);
        end
        sum_s  = p_r ^ bit_c_s;
        cout_s = grp_c_s[NG];
        ovf_s  = bit_c_s[WIDTH-1] ^ grp_c_s[NG];
        zero_s = ~|sum_s;
    end

    // Stage 2 / output registers: hold while stalled, retain when empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r <= 1'b0;
            sum_r      <= '0;
            cout_r     <= 1'b0;
            ovf_r      <= 1'b0;
            zero_r     <= 1'b0;
        end else if (s2_load_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                sum_r  <= sum_s;
                cout_r <= cout_s;
                ovf_r  <= ovf_s;
                zero_r <= zero_s;
            end
        end
    end

    assign out_valid = s2_valid_r;
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;
    assign zero      = zero_r;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Self-checking bench for cla_addsub_pipe (WIDTH = 16): directed vector table,
// backpressure and mid-flight reset sequences, and a randomized stream
// checked against an integer-arithmetic reference model.
module tb_cla_addsub_pipe;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;

    int pass_cnt  = 0;
    int total_cnt = 0;

    cla_addsub_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic         cin;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_ovf;
        logic         exp_zero;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference: plain unsigned/signed integer arithmetic, result {sum,cout,ovf,zero}
    function automatic logic [W+2:0] ref_model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                               input logic sv, input logic cv);
        longint ua, ub, sa, sb, ures, sres;
        logic [W-1:0] s;
        logic co, ov;
        ua = longint'(av);
        ub = longint'(bv);
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        if (sv) begin
            ures = ua - ub;
            sres = sa - sb;
            co   = (ua >= ub);
        end else begin
            ures = ua + ub + longint'(cv);
            sres = sa + sb + longint'(cv);
            co   = (ures >= 65536);
        end
        s  = ures[W-1:0];
        ov = (sres > 32767) || (sres < -32768);
        return {s, co, ov, (s == '0)};
    endfunction

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = 16'hFFFF;
            1:       v = 16'h8000;
            2:       v = 16'h0000;
            3:       v = 16'h7FFF;
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    task automatic drive(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                         input logic cv, input logic iv);
        a        = av;
        b        = bv;
        sub      = sv;
        cin      = cv;
        in_valid = iv;
    endtask

    // Scoreboard monitor, sampling on the falling edge
    logic [W+2:0] exp_q[$];
    bit           sb_en = 1'b0;
    int           n_in  = 0;
    int           n_out = 0;
    logic [W+2:0] held_v;
    bit           held_ok = 1'b0;

    always @(negedge clk) begin
        logic [W+2:0] e;
        if (sb_en) begin
            if (out_valid && held_ok) check("stall_hold", 64'({sum, cout, ovf, zero}), 64'(held_v));
            held_ok = out_valid && !out_ready;
            held_v  = {sum, cout, ovf, zero};
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL stream_unexpected_out: got sum 0x%0h with no beat outstanding", sum);
                end else begin
                    e = exp_q.pop_front();
                    check("stream_result", 64'({sum, cout, ovf, zero}), 64'(e));
                end
            end
            if (in_valid && in_ready) begin
                n_in++;
                exp_q.push_back(ref_model(a, b, sub, cin));
            end
        end else begin
            held_ok = 1'b0;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W+2:0] ea, eb, ec, ef;
        int cyc;

        vecs[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{16'h1234, 16'h0000, 1'b0, 1'b1, 16'h1235, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{16'h1234, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
        vecs[9]  = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{16'h0003, 16'h0001, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{16'h00FF, 16'hFF01, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0};

        // Reset state
        rst_n     = 1'b0;
        out_ready = 1'b0;
        drive(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        #12;
        check("reset_outputs", 64'({out_valid, sum, cout, ovf, zero}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_in_ready", 64'(in_ready), 64'(1));

        // Directed vectors: one beat each, result visible two edges later
        for (int i = 0; i < 13; i++) begin
            out_ready = 1'b1;
            drive(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, 1'b1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            check($sformatf("vec%0d_latency_early", i), 64'(out_valid), 64'(0));
            @(posedge clk); #1;
            check($sformatf("vec%0d_result", i), 64'({out_valid, sum, cout, ovf, zero}),
                  64'({1'b1, vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf, vecs[i].exp_zero}));
        end
        @(posedge clk); #1;

        // Backpressure: A, B accepted, C held until the consumer resumes
        ea = ref_model(16'h1111, 16'h2222, 1'b0, 1'b1);
        eb = ref_model(16'h9000, 16'h1000, 1'b1, 1'b0);
        ec = ref_model(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        out_ready = 1'b0;
        drive(16'h1111, 16'h2222, 1'b0, 1'b1, 1'b1);
        check("bp_empty", 64'(out_valid), 64'(0));
        check("bp_accept_a", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        drive(16'h9000, 16'h1000, 1'b1, 1'b0, 1'b1);
        check("bp_accept_b", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        drive(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        check("bp_full", 64'(in_ready), 64'(0));
        check("bp_out_a", 64'({out_valid, sum, cout, ovf, zero}), 64'({1'b1, ea}));
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("bp_still_full", 64'(in_ready), 64'(0));
            check("bp_hold_a", 64'({out_valid, sum, cout, ovf, zero}), 64'({1'b1, ea}));
        end
        out_ready = 1'b1;
        #1;
        check("bp_ready_comb", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_out_b", 64'({out_valid, sum, cout, ovf, zero}), 64'({1'b1, eb}));
        @(posedge clk); #1;
        check("bp_out_c", 64'({out_valid, sum, cout, ovf, zero}), 64'({1'b1, ec}));
        @(posedge clk); #1;
        check("bp_empty_retain", 64'({out_valid, sum, cout, ovf, zero}), 64'({1'b0, ec}));

        // Asynchronous reset with two beats in flight
        out_ready = 1'b0;
        drive(16'h0102, 16'h0304, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(16'h5555, 16'h1111, 1'b1, 1'b0, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("rst_pre_valid", 64'(out_valid), 64'(1));
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_async_clear", 64'({out_valid, sum, cout, ovf, zero}), 64'(0));
        #10;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rst_no_ghost", 64'(out_valid), 64'(0));
        end
        ef = ref_model(16'hABCD, 16'h0123, 1'b1, 1'b1);
        drive(16'hABCD, 16'h0123, 1'b1, 1'b1, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("rst_new_early", 64'(out_valid), 64'(0));
        @(posedge clk); #1;
        check("rst_new_result", 64'({out_valid, sum, cout, ovf, zero}), 64'({1'b1, ef}));
        @(posedge clk); #1;

        // Randomized stream against the reference model
        sb_en = 1'b1;
        cyc   = 0;
        while (n_in < 1000 && cyc < 20000) begin
            drive(pick_operand(), pick_operand(), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) != 0));
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        @(posedge clk); #1;
        sb_en = 1'b0;
        check("stream_budget", 64'(n_in >= 1000), 64'(1));
        check("stream_count", 64'(n_out), 64'(n_in));
        check("stream_drained", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
